simple_dual_port_ram: RTL and testbench
=======================================

# simple_dual_port_ram

Single-clock simple dual-port RAM: one write port and one independent read port. It has per-byte write enables, a selectable read latency of 1 or 2 cycles with a read-valid strobe, and a defined same-address collision policy. It is the parametrised successor to the team's single-port RAM. It sits under FIFOs, line buffers and packet stores that must write and read in the same cycle.

## Interface
Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = WIDTH/BYTE_WIDTH lanes.
- DEPTH, 16, number of words; DEPTH >= 2; need not be a power of two.
- READ_LATENCY, 1, read latency in cycles; legal values are 1 or 2.
- MODE, "READ_FIRST", same-address collision policy; "READ_FIRST" or "WRITE_FIRST".

Ports (AW = $clog2(DEPTH)):
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  AW  write address.
- wr_be  in  NB  byte-lane enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  AW  read address.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  one-cycle strobe marking rd_data as the result of an accepted read.
- busy  out  1  high while the block ignores requests.

## Operation
- Write accepted when wr_en=1 and busy=0 and wr_addr<DEPTH: only lanes with wr_be[i]=1 update; other lanes keep old contents. wr_be=0 is a no-op.
- wr_addr>=DEPTH: write dropped, memory unchanged.
- Read accepted when rd_en=1 and busy=0: returns mem[rd_addr]. rd_addr>=DEPTH returns all zeros, still with rd_valid.
- Collision: accepted write and accepted read in the same cycle at the same address.
  - READ_FIRST: returns the pre-write word.
  - WRITE_FIRST: returns the merged word (enabled lanes new, other lanes old).
- Different addresses in the same cycle: fully independent.
- rd_data holds its last value between reads; it changes only when rd_valid pulses, or on reset.
- Reset:
  - rd_data=0, rd_valid=0, all pipeline stages and their valid bits cleared.
  - Reads in flight when rst rises are discarded and produce no rd_valid.
  - Memory contents are retained, except when the configuration macro below is defined.
- busy=0 always, except when the configuration macro below is defined.
- The behaviour of illegal parameter combinations is undefined; the block should flag them with an elaboration-time $error.

## Timing
- Write: the new value is visible to a non-colliding read issued in the next cycle.
- READ_LATENCY=1: read accepted at edge N gives rd_data and rd_valid=1 after edge N+1.
- READ_LATENCY=2: read accepted at edge N gives rd_data and rd_valid=1 after edge N+2.
  - The second stage is a plain output register.
  - The collision policy is resolved at stage 1.
- Throughput is one read and one write per cycle; back-to-back reads give back-to-back rd_valid pulses.
- There is no backpressure; the consumer must accept every rd_valid.

## Configuration
- SIMPLE_DUAL_PORT_RAM_INIT_CLEAR_EN defined:
  - Reset runs a hardware clear of the whole memory, driven by a counter and a two-state machine, IDLE and CLEAR.
  - While rst=1: state=CLEAR, counter=0, busy=1.
  - After rst falls: one word per cycle is written to zero at addresses 0..DEPTH-1. busy stays 1 for exactly DEPTH cycles after rst deasserts, then state goes to IDLE and busy goes to 0.
  - During CLEAR, wr_en and rd_en are ignored and no rd_valid is produced.
  - rst reasserted mid-clear restarts the clear from address 0.
- Macro undefined:
  - No clear logic; memory powers up undefined and survives reset.
  - busy is tied to 0.

## Test plan
- Byte-enable merge: write 0x11223344 to addr 3 with be=1111, then 0xAABBCCDD with be=0101, then read addr 3 → rd_data=0x11BB33DD, rd_valid exactly one cycle.
- Collision: memory at addr 5 = 0x00000000; same cycle, write 0xDEADBEEF be=1111 to addr 5 and read addr 5 → READ_FIRST returns 0x00000000, WRITE_FIRST returns 0xDEADBEEF.
- Latency: READ_LATENCY=2, reads of addrs 0,1,2 on consecutive cycles → three consecutive rd_valid pulses starting 2 cycles after the first rd_en, data in order.
- Reset mid-read: READ_LATENCY=2, rd_en at cycle N, rst at N+1 → no rd_valid, rd_data=0, memory data unchanged (macro off).
- Out of range: DEPTH=10, write to addr 12, then read addr 12 and addr 2 → addr 12 reads 0, addr 2 unchanged.
- Init clear (macro on): fill memory with 0xFF…, pulse rst 1 cycle → busy high for DEPTH cycles with rd_en ignored; then every address reads 0.

Source files
------------

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram: 1W/1R single-clock RAM, byte enables, 1-2 cycle reads.
// Define SIMPLE_DUAL_PORT_RAM_INIT_CLEAR_EN to zero the array after reset.
module simple_dual_port_ram #(
  parameter int    WIDTH        = 32,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    DEPTH        = 16,
  parameter int    READ_LATENCY = 1,
  parameter string MODE         = "READ_FIRST",
  localparam int   NB           = WIDTH / BYTE_WIDTH,
  localparam int   AW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [NB-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy
);

  if (BYTE_WIDTH < 1 || WIDTH < BYTE_WIDTH || WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("simple_dual_port_ram: WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("simple_dual_port_ram: DEPTH must be >= 2");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("simple_dual_port_ram: READ_LATENCY must be 1 or 2");
  end
  if (MODE != "READ_FIRST" && MODE != "WRITE_FIRST") begin : g_bad_mode
    $error("simple_dual_port_ram: MODE must be READ_FIRST or WRITE_FIRST");
  end

  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam bit          WR_FIRST = (MODE == "WRITE_FIRST");

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_hit;
  logic             rd_hit;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] rd_old;
  logic [WIDTH-1:0] rd_word;

  assign wr_hit = {1'b0, wr_addr} < DEPTH_W;
  assign rd_hit = {1'b0, rd_addr} < DEPTH_W;
  assign wr_acc = wr_en && !busy && wr_hit;
  assign rd_acc = rd_en && !busy;
  assign rd_old = rd_hit ? mem[rd_addr] : '0;

  // Write-first forwards the enabled lanes of a same-address write.
  always_comb begin
    rd_word = rd_old;
    if (WR_FIRST && wr_acc && wr_addr == rd_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

`ifdef SIMPLE_DUAL_PORT_RAM_INIT_CLEAR_EN
  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_CLEAR = 1'b1;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic [AW-1:0] clr_addr;
  logic          clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_addr == LAST) begin
        state <= S_IDLE;
      end
      clr_addr <= clr_addr + 1'b1;
    end
  end

  assign busy   = (state == S_CLEAR);
  assign clr_we = (state == S_CLEAR) && !rst;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
`ifdef SIMPLE_DUAL_PORT_RAM_INIT_CLEAR_EN
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end
`endif
    if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rd_valid = s2_valid;
    assign rd_data  = s2_data;
  end else begin : g_lat1
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
  end

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// tb_simple_dual_port_ram: two configurations driven in lockstep,
// (DEPTH 10, 2-cycle, READ_FIRST) and (DEPTH 16, 1-cycle, WRITE_FIRST).
module tb_simple_dual_port_ram;

  localparam int DA = 10;
  localparam int DB = 16;
  localparam int LA = 2;
  localparam int LB = 1;

  typedef struct {
    int          due;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data_a;
  logic        rd_valid_a;
  logic        busy_a;
  logic [31:0] rd_data_b;
  logic        rd_valid_b;
  logic        busy_b;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] ma [16];
  logic [31:0] mb [16];
  logic [31:0] hold_a = '0;
  logic [31:0] hold_b = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_on = 1'b0;

  simple_dual_port_ram #(
    .WIDTH(32), .BYTE_WIDTH(8), .DEPTH(DA),
    .READ_LATENCY(LA), .MODE("READ_FIRST")
  ) u_a (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .busy(busy_a)
  );

  simple_dual_port_ram #(
    .WIDTH(32), .BYTE_WIDTH(8), .DEPTH(DB),
    .READ_LATENCY(LB), .MODE("WRITE_FIRST")
  ) u_b (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                        logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) o[i*8 +: 8] = n[i*8 +: 8];
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_valid_a) begin
        exp_t e;
        check("a_unexpected_valid", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_latency", cyc, e.due);
          check("a_data", rd_data_a, e.d);
          hold_a = e.d;
        end
      end else begin
        check("a_hold", rd_data_a, hold_a);
        check("a_missed_valid", 32'(qa.size() != 0 && qa[0].due <= cyc), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_valid_b) begin
        exp_t e;
        check("b_unexpected_valid", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("b_latency", cyc, e.due);
          check("b_data", rd_data_b, e.d);
          hold_b = e.d;
        end
      end else begin
        check("b_hold", rd_data_b, hold_b);
        check("b_missed_valid", 32'(qb.size() != 0 && qb[0].due <= cyc), 32'd0);
      end
    end
  end

  task automatic step(bit we, int wa, logic [3:0] be, logic [31:0] wd,
                      bit re, int ra);
    exp_t        e;
    logic [31:0] o;
    wr_en   = we;
    wr_addr = 4'(wa);
    wr_be   = be;
    wr_data = wd;
    rd_en   = re;
    rd_addr = 4'(ra);
    if (re) begin
      o = (ra < DA) ? ma[ra] : 32'd0;
      e.due = cyc + LA;
      e.d   = o;
      qa.push_back(e);
      o = (ra < DB) ? mb[ra] : 32'd0;
      if (we && wa == ra && wa < DB) o = merge(o, wd, be);
      e.due = cyc + LB;
      e.d   = o;
      qb.push_back(e);
    end
    if (we && wa < DA) ma[wa] = merge(ma[wa], wd, be);
    if (we && wa < DB) mb[wa] = merge(mb[wa], wd, be);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 0, 4'h0, 32'h0, 1'b0, 0);
  endtask

  task automatic do_reset(int cycles);
    int na;
    int nb;
    rst = 1'b1;
    @(posedge clk);
    #1;
    qa.delete();
    qb.delete();
    hold_a = '0;
    hold_b = '0;
    check("a_rst_data", rd_data_a, 32'd0);
    check("a_rst_valid", 32'(rd_valid_a), 32'd0);
    check("b_rst_data", rd_data_b, 32'd0);
    check("b_rst_valid", 32'(rd_valid_b), 32'd0);
`ifdef SIMPLE_DUAL_PORT_RAM_INIT_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    check("a_busy_in_rst", 32'(busy_a), 32'd1);
    check("b_busy_in_rst", 32'(busy_b), 32'd1);
`endif
    repeat (cycles - 1) @(posedge clk);
    #1;
    rst = 1'b0;
    na = 0;
    nb = 0;
    for (int k = 0; k < 40 && (busy_a || busy_b); k++) begin
      wr_en   = busy_a && busy_b;
      wr_addr = 4'd0;
      wr_be   = 4'hF;
      wr_data = 32'hFFFF_FFFF;
      rd_en   = busy_a && busy_b;
      rd_addr = 4'd0;
      na += int'(busy_a);
      nb += int'(busy_b);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifdef SIMPLE_DUAL_PORT_RAM_INIT_CLEAR_EN
    check("a_busy_cycles", na, DA);
    check("b_busy_cycles", nb, DB);
`else
    check("a_busy_cycles", na, 0);
    check("b_busy_cycles", nb, 0);
`endif
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_be   = '0;
    wr_data = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
    for (int i = 0; i < 16; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    do_reset(2);
    mon_on = 1'b1;

    for (int i = 0; i < 16; i++) step(1'b1, i, 4'hF, 32'hC0DE_0000 + i, 1'b0, 0);
    for (int i = 0; i < 16; i++) step(1'b0, 0, 4'h0, 32'h0, 1'b1, i);

    step(1'b1, 3, 4'hF, 32'h1122_3344, 1'b0, 0);
    step(1'b1, 3, 4'b0101, 32'hAABB_CCDD, 1'b0, 0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 3);
    idle(3);

    step(1'b1, 5, 4'hF, 32'h0, 1'b0, 0);
    step(1'b1, 5, 4'hF, 32'hDEAD_BEEF, 1'b1, 5);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 5);
    step(1'b1, 5, 4'b0011, 32'h1234_5678, 1'b1, 5);
    idle(2);

    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 1);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 2);
    idle(3);

    step(1'b1, 7, 4'hF, 32'hCAFE_F00D, 1'b1, 3);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 7);
    step(1'b1, 7, 4'h0, 32'hFFFF_FFFF, 1'b1, 7);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 7);

    step(1'b1, 12, 4'hF, 32'h5555_AAAA, 1'b0, 0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 12);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 2);
    idle(3);

    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 1);
    do_reset(1);
    idle(4);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 1);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 3);
    idle(2);

    repeat (80) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 4'($urandom),
           32'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end
    idle(3);

    for (int i = 0; i < 16; i++) step(1'b1, i, 4'hF, 32'hFFFF_FFFF, 1'b0, 0);
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1'b0, 0, 4'h0, 32'h0, 1'b1, i);
    idle(5);

    check("a_drain", qa.size(), 32'd0);
    check("b_drain", qb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
